// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester single-port RAM arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Consecutive data grants tolerated while a fetch is pending.
    localparam logic [1:0] STARVE_MAX = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick between fetch and data requesters with starvation override.
// Latency: purely combinational.
// Backpressure: none here; the parent gates the picks with its grant window.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic [1:0] starve_cnt,
    output logic       grant_if,
    output logic       grant_d
);

    // Data normally wins a tie; fetch wins once it has been passed over STARVE_MAX times.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_req && d_req) begin
            if (starve_cnt == STARVE_MAX) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_if = if_req;
            grant_d  = d_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port RAM, one access in flight.
// Latency: read response RAM_LAT+1 cycles after grant; write acknowledge 1 cycle after grant.
// Backpressure: requesters hold req until a one-cycle gnt; no grants while a read is outstanding.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    // WAIT runs from LAT_INIT down to 0, i.e. RAM_LAT cycles.
    localparam logic [1:0] LAT_INIT = 2'(RAM_LAT - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [1:0]        starve_q, starve_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_if, pick_d;
    logic              can_grant, gnt_if, gnt_d;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .grant_if   (pick_if),
        .grant_d    (pick_d)
    );

    // Grants only open between accesses; reset masks them so every output reads 0 in reset.
    assign can_grant = !rst && ((state_q == IDLE) || (state_q == RESP));
    assign gnt_if    = can_grant && pick_if;
    assign gnt_d     = can_grant && pick_d;

    // Next-state: finish the outstanding access, then let a new grant override the target state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            WAIT: begin
                if (lat_q == 2'd0) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = ram_rdata;
                    end else begin
                        d_rdata_d = ram_rdata;
                    end
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (gnt_if) begin
            owner_d  = OWN_IF;
            addr_d   = if_addr;
            starve_d = 2'd0;
            state_d  = WAIT;
            lat_d    = LAT_INIT;
        end else if (gnt_d) begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            if (!if_req) begin
                starve_d = 2'd0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 2'd1;
            end
            if (d_we) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
                lat_d   = LAT_INIT;
            end
        end
    end

    // State and datapath registers, cleared asynchronously so an in-flight read is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            starve_q   <= 2'd0;
            lat_q      <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // RAM controls follow the winner in the grant cycle, otherwise the last granted access.
    assign ram_addr  = gnt_if ? if_addr : (gnt_d ? d_addr : addr_q);
    assign ram_wdata = gnt_d ? d_wdata : wdata_q;
    assign ram_w_en  = gnt_d && d_we;

    assign if_gnt   = gnt_if;
    assign d_gnt    = gnt_d;
    assign if_valid = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_valid  = (state_q == RESP) && (owner_q == OWN_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: lane 0 runs RAM_LAT=1, lane 1 runs RAM_LAT=3.
// Latency: expected response cycle is pushed with each grant.
// Backpressure: requesters hold req until gnt, as a real master would.
module tb_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   fails = 0;

    logic          if_req    [2];
    logic [AW-1:0] if_addr   [2];
    logic          if_gnt    [2];
    logic          if_valid  [2];
    logic [DW-1:0] if_rdata  [2];
    logic          d_req     [2];
    logic          d_we      [2];
    logic [AW-1:0] d_addr    [2];
    logic [DW-1:0] d_wdata   [2];
    logic          d_gnt     [2];
    logic          d_valid   [2];
    logic [DW-1:0] d_rdata   [2];
    logic [AW-1:0] ram_addr  [2];
    logic [DW-1:0] ram_wdata [2];
    logic          ram_w_en  [2];
    logic [DW-1:0] ram_rdata [2];
    logic          busy      [2];

    exp_t q0[$];
    exp_t q1[$];
    logic [DW-1:0] last_d [2];
    bit   log_on = 1'b0;
    int   log_lane = 0;
    bit   log_d[$];
    int   log_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_valid(d_valid[0]), .d_rdata(d_rdata[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_w_en(ram_w_en[0]),
        .ram_rdata(ram_rdata[0]), .busy(busy[0])
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_valid(d_valid[1]), .d_rdata(d_rdata[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_w_en(ram_w_en[1]),
        .ram_rdata(ram_rdata[1]), .busy(busy[1])
    );

    // Synchronous RAM models with read pipelines of 1 and 3 stages.
    logic [DW-1:0] mem0 [2048];
    logic [DW-1:0] mem1 [2048];
    logic [DW-1:0] p0, p1a, p1b, p1c;

    always @(posedge clk) begin
        p0 <= mem0[ram_addr[0]];
        if (ram_w_en[0]) mem0[ram_addr[0]] <= ram_wdata[0];
    end

    always @(posedge clk) begin
        p1a <= mem1[ram_addr[1]];
        p1b <= p1a;
        p1c <= p1b;
        if (ram_w_en[1]) mem1[ram_addr[1]] <= ram_wdata[1];
    end

    assign ram_rdata[0] = p0;
    assign ram_rdata[1] = p1c;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Pops and compares one response whenever a lane presents a valid.
    task automatic check_lane(input int k);
        exp_t e;
        logic [DW-1:0] act;
        if (if_gnt[k] || d_gnt[k]) begin
            compared++;
            if ((if_gnt[k] && d_gnt[k]) || busy[k]) begin
                fails++;
                $display("FAIL gnt_legal lane%0d cyc=%0d: if_gnt=%b d_gnt=%b busy=%b, need one gnt with busy=0",
                         k, cyc, if_gnt[k], d_gnt[k], busy[k]);
            end
            if (log_on && log_lane == k) begin
                log_d.push_back(d_gnt[k]);
                log_c.push_back(cyc);
            end
        end
        if (if_valid[k] || d_valid[k]) begin
            compared++;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                fails++;
                $display("FAIL resp_unexpected lane%0d cyc=%0d: if_valid=%b d_valid=%b, need none",
                         k, cyc, if_valid[k], d_valid[k]);
            end else begin
                e   = (k == 0) ? q0.pop_front() : q1.pop_front();
                act = e.is_d ? d_rdata[k] : if_rdata[k];
                if (if_valid[k] !== !e.is_d || d_valid[k] !== e.is_d || act !== e.data || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL resp lane%0d: got if_valid=%b d_valid=%b data=%h cyc=%0d, need is_d=%0d data=%h cyc=%0d",
                             k, if_valid[k], d_valid[k], act, cyc, e.is_d, e.data, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_lane(0);
            check_lane(1);
        end
    end

    task automatic check_reset(input int k, input string tag);
        logic [2*DW+AW+DW+DW+6-1:0] v;
        v = {if_gnt[k], if_valid[k], if_rdata[k], d_gnt[k], d_valid[k], d_rdata[k],
             ram_addr[k], ram_wdata[k], ram_w_en[k], busy[k]};
        compared++;
        if (v !== '0) begin
            fails++;
            $display("FAIL %s lane%0d: outputs=%h, need all zero", tag, k, v);
        end
    endtask

    // One request: hold until gnt, check RAM controls in the grant cycle, queue the response.
    task automatic do_req(input int k, input bit is_d, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_data, output int gcyc);
        int   n;
        bit   got;
        exp_t e;
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = a;
        end
        got = 1'b0;
        n   = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if ((is_d ? d_gnt[k] : if_gnt[k]) === 1'b1) got = 1'b1;
            else n++;
        end
        gcyc = cyc;
        compared++;
        if (!got) begin
            fails++;
            $display("FAIL grant_timeout lane%0d is_d=%0d addr=%h: no gnt in 100 cycles, need gnt", k, is_d, a);
        end else begin
            if (ram_addr[k] !== a || ram_w_en[k] !== (is_d && we) || (is_d && we && ram_wdata[k] !== wd)) begin
                fails++;
                $display("FAIL ram_ctl lane%0d: addr=%h w_en=%b wdata=%h, need addr=%h w_en=%b wdata=%h",
                         k, ram_addr[k], ram_w_en[k], ram_wdata[k], a, is_d && we, wd);
            end
            e.is_d = is_d;
            if (is_d && we) begin
                e.data = last_d[k];
                e.cyc  = cyc + 1;
            end else begin
                e.data = exp_data;
                e.cyc  = cyc + lat_of(k) + 1;
                if (is_d) last_d[k] = exp_data;
            end
            push_exp(k, e);
        end
        @(posedge clk);
        #1;
        if (is_d) d_req[k] = 1'b0;
        else      if_req[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gc, rel_cyc, vcnt, n;
        bit  got;
        bit  exp_ord4 [6];
        bit  exp_ord5 [6];
        exp_ord4 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_ord5 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0; last_d[k] = '0;
        end

        // Reset with a live request: nothing may leak out.
        if_req[0] = 1'b1; if_addr[0] = 11'h155;
        repeat (3) @(negedge clk);
        check_reset(0, "reset_state");
        check_reset(1, "reset_state");
        @(posedge clk); #1;
        if_req[0] = 1'b0;
        rst = 1'b0;
        rel_cyc = cyc;

        // Preload via the data port; the very first grant lands in the release cycle.
        do_req(0, 1'b1, 1'b1, 11'h010, 32'hE3A01005, '0, gc);
        compared++;
        if (gc != rel_cyc) begin
            fails++;
            $display("FAIL first_grant: cyc=%0d, need %0d", gc, rel_cyc);
        end
        do_req(0, 1'b1, 1'b1, 11'h000, 32'h11111111, '0, gc);
        for (int i = 0; i < 3; i++) begin
            do_req(1, 1'b1, 1'b1, 11'h020 + 11'(i), 32'hC0DE0020 + 32'(i), '0, gc);
            do_req(1, 1'b1, 1'b1, 11'h300 + 11'(i), 32'hDA7A0300 + 32'(i), '0, gc);
        end
        idle(3);

        // Fetch-only read, latency 1: busy in N+1, valid in N+2.
        do_req(0, 1'b0, 1'b0, 11'h010, '0, 32'hE3A01005, gc);
        @(negedge clk);
        compared++;
        if (busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL busy_wait: busy=%b, need 1", busy[0]);
        end
        idle(3);

        // Write then read back.
        do_req(0, 1'b1, 1'b1, 11'h200, 32'hDEADBEEF, '0, gc);
        do_req(0, 1'b1, 1'b0, 11'h200, '0, 32'hDEADBEEF, gc);
        idle(3);

        // Top-of-memory write immediately followed by a fetch from address 0.
        do_req(0, 1'b1, 1'b1, 11'h7FF, 32'h0BADF00D, '0, gc);
        do_req(0, 1'b0, 1'b0, 11'h000, '0, 32'h11111111, gc);
        do_req(0, 1'b1, 1'b0, 11'h7FF, '0, 32'h0BADF00D, gc);
        idle(4);

        // Both requesters held: D, D, I, D, D, I.
        log_d.delete(); log_c.delete(); log_lane = 0; log_on = 1'b1;
        fork
            begin
                int g;
                for (int i = 0; i < 4; i++)
                    do_req(0, 1'b1, 1'b1, 11'h100 + 11'(i), 32'h50000000 + 32'(i), '0, g);
            end
            begin
                int g;
                for (int i = 0; i < 2; i++)
                    do_req(0, 1'b0, 1'b0, 11'h010, '0, 32'hE3A01005, g);
            end
        join
        log_on = 1'b0;
        idle(4);
        compared++;
        if (log_d.size() != 6) begin
            fails++;
            $display("FAIL order_len lane0: %0d grants, need 6", log_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                compared++;
                if (log_d[i] != exp_ord4[i]) begin
                    fails++;
                    $display("FAIL order lane0 #%0d: is_d=%0d, need %0d", i, log_d[i], exp_ord4[i]);
                end
            end
        end

        // Back-to-back reads, latency 3: grants 4 cycles apart, steered to the right requester.
        log_d.delete(); log_c.delete(); log_lane = 1; log_on = 1'b1;
        fork
            begin
                int g;
                for (int i = 0; i < 3; i++)
                    do_req(1, 1'b1, 1'b0, 11'h300 + 11'(i), '0, 32'hDA7A0300 + 32'(i), g);
            end
            begin
                int g;
                for (int i = 0; i < 3; i++)
                    do_req(1, 1'b0, 1'b0, 11'h020 + 11'(i), '0, 32'hC0DE0020 + 32'(i), g);
            end
        join
        log_on = 1'b0;
        idle(6);
        compared++;
        if (log_d.size() != 6) begin
            fails++;
            $display("FAIL order_len lane1: %0d grants, need 6", log_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                compared++;
                if (log_d[i] != exp_ord5[i] || (i > 0 && log_c[i] - log_c[i-1] != 4)) begin
                    fails++;
                    $display("FAIL b2b lane1 #%0d: is_d=%0d cyc=%0d, need is_d=%0d spacing 4",
                             i, log_d[i], log_c[i], exp_ord5[i]);
                end
            end
        end

        // Reset in the second WAIT cycle of a latency-3 read discards it.
        if_req[1] = 1'b1; if_addr[1] = 11'h021;
        got = 1'b0; n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (if_gnt[1] === 1'b1) got = 1'b1;
            else n++;
        end
        compared++;
        if (!got) begin
            fails++;
            $display("FAIL grant_timeout rst_case: no gnt, need gnt");
        end
        @(posedge clk); #1;
        if_req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset(1, "reset_in_wait");
        check_reset(0, "reset_in_wait");
        idle(2);
        rst = 1'b0;
        vcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (if_valid[1] || d_valid[1]) vcnt++;
        end
        compared++;
        if (vcnt != 0) begin
            fails++;
            $display("FAIL no_valid_after_rst: %0d valids, need 0", vcnt);
        end
        @(posedge clk); #1;
        do_req(1, 1'b0, 1'b0, 11'h022, '0, 32'hC0DE0022, gc);
        idle(8);

        compared++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d responses outstanding, need 0/0", q0.size(), q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter RAM_LAT, default 1, RAM read latency in cycles; legal values are 1..4.
REQ-004 clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  fetch request; if_addr (in, ADDR_W) is the fetch word address.
REQ-007 if_gnt  out  1  fetch grant pulse; if_valid (out, 1) and if_rdata (out, DATA_W) carry the fetch response.
REQ-008 d_req, d_we  in  1 each  data request and write select; d_addr (in, ADDR_W) is the data address; d_wdata (in, DATA_W) is the write data.
REQ-009 d_gnt  out  1  data grant pulse; d_valid (out, 1) and d_rdata (out, DATA_W) carry the data response or write acknowledge.
REQ-010 ram_addr (out, ADDR_W), ram_wdata (out, DATA_W) and ram_w_en (out, 1) are the single-port RAM controls; ram_rdata (in, DATA_W) is the RAM read data.
REQ-011 busy  out  1  asserted while a read is outstanding (state WAIT).

Function
REQ-012 FSM states: IDLE, WAIT, RESP.
REQ-013 A grant is issued only in IDLE or RESP.
REQ-014 At most one access is outstanding at any time.
REQ-015 A requester holds req, addr, we and wdata stable until its gnt.
REQ-016 gnt is a one-cycle pulse; the requester may drop or change req in the cycle after gnt.
REQ-017 Arbitration with one requester: that requester is granted.
REQ-018 Arbitration with both requesters: data wins unless starve_cnt==2, in which case fetch wins.
REQ-019 starve_cnt (2 bits) increments, saturating at 2, on each data grant while if_req=1.
REQ-020 starve_cnt clears to 0 on a fetch grant, or on a data grant while if_req=0.
REQ-021 In the grant cycle N, ram_addr, ram_wdata and ram_w_en are driven combinationally from the winner; ram_w_en=1 only for a data grant with d_we=1.
REQ-022 Outside grant cycles, ram_w_en=0 and ram_addr/ram_wdata hold the last granted values (registered copy).
REQ-023 Read grant in cycle N: next state is WAIT for RAM_LAT cycles (latency counter).
REQ-024 At the edge ending cycle N+RAM_LAT, ram_rdata is captured into the requester's rdata register.
REQ-025 After a read, the FSM enters RESP in cycle N+RAM_LAT+1 with that requester's valid=1 for exactly one cycle.
REQ-026 Write grant in cycle N: next state is RESP, d_valid=1 in cycle N+1 (acknowledge), and d_rdata is unchanged.
REQ-027 In RESP with no new grant, next state is IDLE; with a new grant, next state follows REQ-023/REQ-026, giving back-to-back throughput.
REQ-028 Read occupancy is RAM_LAT+1 cycles per access; write occupancy is 1 cycle.
REQ-029 if_rdata and d_rdata hold their last captured value until the next capture for that requester.
REQ-030 Simultaneous requests while in WAIT are not granted; they wait for RESP.

Reset
REQ-031 rst forces state IDLE, starve_cnt=0, latency counter=0, and every output (gnt, valid, rdata, ram_*, busy) to 0, independent of clk.
REQ-032 Reset during WAIT discards the in-flight read: no valid pulse is produced after rst deasserts.
REQ-033 After rst deasserts, the first grant may occur in the first clock edge cycle.

Structure
REQ-034 Package mem_arb_pkg holds the state enum (IDLE, WAIT, RESP), the owner enum (OWN_IF, OWN_D), and the STARVE_MAX=2 constant.
REQ-035 Sub-module mem_arb_pick is combinational: inputs if_req, d_req, starve_cnt; outputs grant_if, grant_d.
REQ-036 The owner register records which requester's read is outstanding, for response steering.

Verification
REQ-037 Fetch-only read, RAM_LAT=1, if_addr=0x010, RAM[0x010]=0xE3A01005 -> if_gnt in cycle 0, busy in cycle 1, if_valid=1 with if_rdata=0xE3A01005 in cycle 2.
REQ-038 Data write, d_addr=0x200, d_wdata=0xDEADBEEF -> ram_w_en=1 in the grant cycle, d_valid in the next cycle; a following read of 0x200 returns 0xDEADBEEF.
REQ-039 Both requests held continuously -> grant order D, D, I, D, D, I...; starve_cnt never exceeds 2.
REQ-040 Back-to-back reads with RAM_LAT=3 -> a second grant in each RESP cycle, valid spacing 4 cycles, responses steered to the correct requester.
REQ-041 rst asserted in WAIT cycle 2 of 3 -> outputs clear immediately; no if_valid/d_valid afterwards; a new request after release is served normally.
REQ-042 Write at 0x7FF followed immediately by a fetch at 0x000 -> address wrap boundaries are correct; ram_w_en=0 during the fetch.
